// File: rtl/adc_conv_sequencer_if.sv
// adc_conv_sequencer_if: control, ADC core, result FIFO and status signals of the conversion sequencer
interface adc_conv_sequencer_if #(parameter int FIFO_DEPTH = 4);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  logic start_single_in;
  logic start_cont_in;
  logic stop_in;
  logic [7:0] num_samples_in;
  logic core_rst_n_out;
  logic core_conv_finished_in;
  logic [9:0] core_result_in;
  logic rd_en_in;
  logic [9:0] rd_data_out;
  logic fifo_empty_out;
  logic fifo_full_out;
  logic [LW-1:0] fifo_level_out;
  logic busy_out;
  logic done_out;
  logic overflow_out;
  logic timeout_out;
  logic clear_flags_in;
  modport master (
    output start_single_in, start_cont_in, stop_in, num_samples_in, core_conv_finished_in,
           core_result_in, rd_en_in, clear_flags_in,
    input  core_rst_n_out, rd_data_out, fifo_empty_out, fifo_full_out, fifo_level_out,
           busy_out, done_out, overflow_out, timeout_out
  );
  modport slave (
    input  start_single_in, start_cont_in, stop_in, num_samples_in, core_conv_finished_in,
           core_result_in, rd_en_in, clear_flags_in,
    output core_rst_n_out, rd_data_out, fifo_empty_out, fifo_full_out, fifo_level_out,
           busy_out, done_out, overflow_out, timeout_out
  );
endinterface

// File: rtl/adc_conv_sequencer.sv
// adc_conv_sequencer: sequences single/burst ADC conversions and buffers results in a FWFT FIFO
module adc_conv_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int ARM_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input logic clk,
  input logic rst,
  adc_conv_sequencer_if.slave bus
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int ARW = $clog2(ARM_CYCLES + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, ARM, CONVERT, FINISH} state_t;
  state_t state_q, state_d;
  logic single_q, single_d, stop_q, stop_d;
  logic [7:0] num_q, num_d, cnt_q, cnt_d, cnt_inc;
  logic [ARW-1:0] arm_q, arm_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [2:0] sync_q, sync_d;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d, level;
  logic [9:0] mem_q [FIFO_DEPTH];
  logic [9:0] mem_d [FIFO_DEPTH];
  logic ovf_q, ovf_d, tflag_q, tflag_d;
  logic evt, push, pop, full, empty, wr_ok, last, tmo_set;
  // sync_q[1] is the synchronized level, sync_q[2] its previous value for edge detection
  assign sync_d  = {sync_q[1:0], bus.core_conv_finished_in};
  assign evt     = sync_q[1] & ~sync_q[2];
  assign push    = evt && state_q == CONVERT;
  assign level   = wr_q - rd_q;
  assign full    = level == (AW+1)'(FIFO_DEPTH);
  assign empty   = level == '0;
  assign pop     = bus.rd_en_in & ~empty;
  assign wr_ok   = push & (~full | pop);
  assign cnt_inc = cnt_q + 8'd1;
  assign last    = single_q | (num_q != 8'd0 && cnt_inc == num_q) | stop_q | bus.stop_in;
  always_comb begin
    state_d  = state_q;
    single_d = single_q;
    stop_d   = stop_q;
    num_d    = num_q;
    cnt_d    = cnt_q;
    arm_d    = arm_q;
    tmo_d    = tmo_q;
    tmo_set  = 1'b0;
    case (state_q)
      IDLE: if (bus.start_single_in | bus.start_cont_in) begin
        state_d  = ARM;
        single_d = bus.start_single_in;
        num_d    = bus.num_samples_in;
        cnt_d    = '0;
        arm_d    = '0;
      end
      ARM: begin
        stop_d = stop_q | bus.stop_in;
        arm_d  = arm_q + 1'b1;
        if (arm_q == ARW'(ARM_CYCLES - 1)) begin
          state_d = CONVERT;
          tmo_d   = '0;
        end
      end
      CONVERT: begin
        stop_d = stop_q | bus.stop_in;
        if (evt) begin
          cnt_d   = cnt_inc;
          tmo_d   = '0;
          state_d = last ? FINISH : CONVERT;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          tmo_set = 1'b1;
          state_d = FINISH;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      FINISH: begin
        stop_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    mem_d = mem_q;
    if (wr_ok) mem_d[wr_q[AW-1:0]] = bus.core_result_in;
    wr_d    = wr_ok ? wr_q + 1'b1 : wr_q;
    rd_d    = pop ? rd_q + 1'b1 : rd_q;
    ovf_d   = (push & full & ~pop) | (ovf_q & ~bus.clear_flags_in);
    tflag_d = tmo_set | (tflag_q & ~bus.clear_flags_in);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      single_q <= 1'b0;
      stop_q   <= 1'b0;
      num_q    <= '0;
      cnt_q    <= '0;
      arm_q    <= '0;
      tmo_q    <= '0;
      sync_q   <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      mem_q    <= '{default: '0};
      ovf_q    <= 1'b0;
      tflag_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      single_q <= single_d;
      stop_q   <= stop_d;
      num_q    <= num_d;
      cnt_q    <= cnt_d;
      arm_q    <= arm_d;
      tmo_q    <= tmo_d;
      sync_q   <= sync_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      mem_q    <= mem_d;
      ovf_q    <= ovf_d;
      tflag_q  <= tflag_d;
    end
  end
  assign bus.rd_data_out    = mem_q[rd_q[AW-1:0]];
  assign bus.fifo_level_out = level;
  assign bus.fifo_empty_out = empty;
  assign bus.fifo_full_out  = full;
  assign bus.busy_out       = state_q != IDLE;
  assign bus.done_out       = state_q == FINISH;
  assign bus.core_rst_n_out = state_q == ARM || state_q == CONVERT;
  assign bus.overflow_out   = ovf_q;
  assign bus.timeout_out    = tflag_q;
endmodule

// File: tb/tb_adc_conv_sequencer.sv
// tb_adc_conv_sequencer: directed checks of single, burst, overflow, timeout and reset behaviour
module tb_adc_conv_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_asrt = 0;
  int n_fail = 0;
  int done_cnt = 0;
  adc_conv_sequencer_if #(.FIFO_DEPTH(4)) bus ();
  adc_conv_sequencer #(.FIFO_DEPTH(4), .ARM_CYCLES(2), .TIMEOUT_CYCLES(4095)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.done_out === 1'b1) done_cnt++;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic conv(input logic [9:0] r);
    bus.core_result_in = r;
    bus.core_conv_finished_in = 1'b1;
    step(5);
    bus.core_conv_finished_in = 1'b0;
    step(4);
  endtask
  task automatic pop1();
    bus.rd_en_in = 1'b1;
    step(1);
    bus.rd_en_in = 1'b0;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, bus.busy_out, 0);
    chk({tag, "_core_rst_n"}, bus.core_rst_n_out, 0);
    chk({tag, "_empty"}, bus.fifo_empty_out, 1);
    chk({tag, "_full"}, bus.fifo_full_out, 0);
    chk({tag, "_level"}, bus.fifo_level_out, 0);
    chk({tag, "_rd_data"}, bus.rd_data_out, 0);
    chk({tag, "_done"}, bus.done_out, 0);
    chk({tag, "_overflow"}, bus.overflow_out, 0);
    chk({tag, "_timeout"}, bus.timeout_out, 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.start_single_in = 0;
    bus.start_cont_in = 0;
    bus.stop_in = 0;
    bus.num_samples_in = 0;
    bus.core_conv_finished_in = 0;
    bus.core_result_in = 0;
    bus.rd_en_in = 0;
    bus.clear_flags_in = 0;
    step(3);
    chk_reset("por");
    rst = 0;
    step(1);
    // single conversion with result 0x2A5
    bus.core_result_in = 10'h2A5;
    bus.start_single_in = 1;
    step(1);
    bus.start_single_in = 0;
    chk("s_arm_busy", bus.busy_out, 1);
    chk("s_arm_core_rst_n", bus.core_rst_n_out, 1);
    step(2);
    chk("s_conv_core_rst_n", bus.core_rst_n_out, 1);
    bus.core_conv_finished_in = 1;
    step(3);
    chk("s_level", bus.fifo_level_out, 1);
    chk("s_head", bus.rd_data_out, 10'h2A5);
    chk("s_done", bus.done_out, 1);
    chk("s_finish_core_rst_n", bus.core_rst_n_out, 0);
    step(1);
    chk("s_idle_busy", bus.busy_out, 0);
    chk("s_done_once", done_cnt, 1);
    bus.core_conv_finished_in = 0;
    step(3);
    pop1();
    chk("s_empty_after_pop", bus.fifo_empty_out, 1);
    // burst of three
    bus.num_samples_in = 8'd3;
    bus.start_cont_in = 1;
    step(1);
    bus.start_cont_in = 0;
    bus.num_samples_in = 0;
    step(2);
    conv(10'd1);
    chk("b3_level1", bus.fifo_level_out, 1);
    chk("b3_busy1", bus.busy_out, 1);
    conv(10'd2);
    chk("b3_level2", bus.fifo_level_out, 2);
    chk("b3_no_done", done_cnt, 1);
    conv(10'd3);
    chk("b3_level3", bus.fifo_level_out, 3);
    chk("b3_busy_end", bus.busy_out, 0);
    chk("b3_done", done_cnt, 2);
    chk("b3_head1", bus.rd_data_out, 1);
    pop1();
    chk("b3_head2", bus.rd_data_out, 2);
    pop1();
    chk("b3_head3", bus.rd_data_out, 3);
    pop1();
    chk("b3_empty", bus.fifo_empty_out, 1);
    chk("b3_stale_head", bus.rd_data_out, 10'h2A5);
    pop1();
    chk("empty_pop_level", bus.fifo_level_out, 0);
    chk("empty_pop_head", bus.rd_data_out, 10'h2A5);
    // unlimited burst into a full FIFO
    bus.stop_in = 1;
    step(1);
    bus.stop_in = 0;
    bus.start_cont_in = 1;
    step(1);
    bus.start_cont_in = 0;
    step(2);
    conv(10'h10);
    chk("u_stop_idle_ignored", bus.busy_out, 1);
    conv(10'h11);
    conv(10'h12);
    conv(10'h13);
    chk("u_level4", bus.fifo_level_out, 4);
    chk("u_full", bus.fifo_full_out, 1);
    chk("u_no_overflow", bus.overflow_out, 0);
    bus.start_single_in = 1;
    step(1);
    bus.start_single_in = 0;
    conv(10'h14);
    chk("u_overflow", bus.overflow_out, 1);
    chk("u_level_hold", bus.fifo_level_out, 4);
    chk("u_start_ignored", bus.busy_out, 1);
    bus.stop_in = 1;
    step(1);
    bus.stop_in = 0;
    step(3);
    chk("u_stop_pending_busy", bus.busy_out, 1);
    chk("u_stop_no_done", done_cnt, 2);
    conv(10'h15);
    chk("u_done", done_cnt, 3);
    chk("u_idle", bus.busy_out, 0);
    chk("u_head", bus.rd_data_out, 10'h10);
    bus.clear_flags_in = 1;
    step(1);
    bus.clear_flags_in = 0;
    chk("clr_overflow", bus.overflow_out, 0);
    // push and pop together while full
    bus.core_result_in = 10'h20;
    bus.start_single_in = 1;
    step(1);
    bus.start_single_in = 0;
    step(2);
    bus.core_conv_finished_in = 1;
    step(2);
    bus.rd_en_in = 1;
    step(1);
    bus.rd_en_in = 0;
    chk("pp_level", bus.fifo_level_out, 4);
    chk("pp_full", bus.fifo_full_out, 1);
    chk("pp_no_overflow", bus.overflow_out, 0);
    chk("pp_head", bus.rd_data_out, 10'h11);
    chk("pp_done", bus.done_out, 1);
    bus.core_conv_finished_in = 0;
    step(4);
    pop1();
    chk("pp_head12", bus.rd_data_out, 10'h12);
    pop1();
    chk("pp_head13", bus.rd_data_out, 10'h13);
    pop1();
    chk("pp_head20", bus.rd_data_out, 10'h20);
    pop1();
    chk("pp_empty", bus.fifo_empty_out, 1);
    // timeout when the core never finishes
    bus.start_single_in = 1;
    step(1);
    bus.start_single_in = 0;
    step(4096);
    chk("to_not_yet", bus.timeout_out, 0);
    chk("to_busy", bus.busy_out, 1);
    step(1);
    chk("to_set", bus.timeout_out, 1);
    chk("to_done", bus.done_out, 1);
    chk("to_core_rst_n", bus.core_rst_n_out, 0);
    step(1);
    chk("to_idle", bus.busy_out, 0);
    chk("to_done_cnt", done_cnt, 5);
    bus.clear_flags_in = 1;
    step(1);
    bus.clear_flags_in = 0;
    chk("to_clear", bus.timeout_out, 0);
    // reset during a conversion with two entries held
    bus.start_cont_in = 1;
    step(1);
    bus.start_cont_in = 0;
    step(2);
    conv(10'h30);
    conv(10'h31);
    chk("r_level2", bus.fifo_level_out, 2);
    bus.core_result_in = 10'h32;
    bus.core_conv_finished_in = 1;
    step(2);
    rst = 1;
    #2;
    chk_reset("mid");
    step(2);
    bus.core_conv_finished_in = 0;
    step(2);
    rst = 0;
    step(4);
    chk("r_no_done", done_cnt, 5);
    chk("r_level_after", bus.fifo_level_out, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/adc_conv_sequencer.md
ADC_CONV_SEQUENCER -- requirements
Module: adc_conv_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, result FIFO entries; power of two, >=2.
REQ-002 Parameter ARM_CYCLES, default 2, cycles the core is held out of reset before waiting for a result.
REQ-003 Parameter TIMEOUT_CYCLES, default 4095, max cycles in CONVERT without a result.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start_single_in  in  1  one-cycle pulse; request one conversion.
REQ-007 start_cont_in  in  1  one-cycle pulse; request a burst.
REQ-008 stop_in  in  1  one-cycle pulse; end a burst after the current conversion.
REQ-009 num_samples_in  in  8  burst length, sampled at start; 0 = unlimited.
REQ-010 core_rst_n_out  out  1  drives ADC core active-low reset.
REQ-011 core_conv_finished_in  in  1  ADC core conversion-finished level, asynchronous to clk.
REQ-012 core_result_in  in  10  ADC core result; stable while core_conv_finished_in is high.
REQ-013 rd_en_in  in  1  pop FIFO head.
REQ-014 rd_data_out  out  10  FIFO head, first-word-fall-through.
REQ-015 fifo_empty_out / fifo_full_out  out  1 each  FIFO status.
REQ-016 fifo_level_out  out  clog2(FIFO_DEPTH)+1  entries held.
REQ-017 busy_out  out  1  high in any state other than IDLE.
REQ-018 done_out  out  1  one-cycle pulse at end of a single conversion or burst.
REQ-019 overflow_out / timeout_out  out  1 each  sticky error flags.
REQ-020 clear_flags_in  in  1  clears overflow_out and timeout_out.

Function
REQ-021 FSM states SHALL be IDLE, ARM, CONVERT, FINISH.
REQ-022 core_rst_n_out SHALL be 0 in IDLE and FINISH and 1 in ARM and CONVERT.
REQ-023 IDLE: start_single_in -> ARM, mode=single; start_cont_in -> ARM, mode=burst, latch num_samples_in, sample count := 0; both together -> single wins.
REQ-024 ARM SHALL last exactly ARM_CYCLES cycles, then -> CONVERT with timeout counter := 0.
REQ-025 core_conv_finished_in SHALL pass a 2-flop synchronizer; a rising edge of the synchronized level is a result event (one per conversion).
REQ-026 On a result event in CONVERT, core_result_in SHALL be pushed in that same cycle, sample count incremented (8-bit, wraps), timeout counter cleared.
REQ-027 After a result event: single mode, latched count reached (non-zero), or stop pending -> FINISH; otherwise stay in CONVERT.
REQ-028 stop_in in ARM/CONVERT SHALL set stop pending; stop and result event same cycle -> sample pushed, then FINISH.
REQ-029 Timeout counter increments each CONVERT cycle; reaching TIMEOUT_CYCLES without an event -> set timeout_out, -> FINISH.
REQ-030 FINISH SHALL last one cycle, pulse done_out (also on timeout), clear stop pending, -> IDLE.
REQ-031 start_*_in outside IDLE SHALL be ignored; stop_in in IDLE SHALL be ignored.
REQ-032 Result events outside CONVERT SHALL be discarded.
REQ-033 Push when full and no simultaneous pop: data dropped, overflow_out set, FIFO unchanged.
REQ-034 Push and pop same cycle when full: both accepted, level unchanged.
REQ-035 Pop when empty SHALL be ignored; rd_data_out holds.
REQ-036 rd_data_out SHALL show head combinationally from storage with no extra latency; updates cycle after pop.
REQ-037 clear_flags_in SHALL clear flags; a new set event in the same cycle wins.

Reset
REQ-038 rst SHALL force IDLE, core_rst_n_out=0, FIFO empty (level 0, empty=1, full=0), rd_data_out=0, busy/done/overflow/timeout=0, counters and synchronizer=0, stop pending=0.
REQ-039 rst asserted mid-conversion SHALL abort immediately without done_out; no partial sample written.

Verification
REQ-040 start_single, core raises finished with result 0x2A5 -> busy, core_rst_n high 2 cycles before CONVERT, FIFO level 1, head 0x2A5, done pulse, core_rst_n low.
REQ-041 start_cont with num_samples=3, results 1,2,3 -> three pushes, done after third, pop order 1,2,3, empty after third pop.
REQ-042 start_cont, num_samples=0, 6 results, no reads, depth 4 -> level 4, full, overflow set after 5th, stop_in -> done after next result.
REQ-043 start_single, finished never rises -> timeout_out set after 4095 CONVERT cycles, done pulse, IDLE; clear_flags_in clears it.
REQ-044 FIFO full, push+pop same cycle -> level stays 4, no overflow, head advances.
REQ-045 rst pulse during CONVERT with 2 entries -> all outputs at reset values, FIFO empty, no done pulse.
